fpga2_receiver: RTL and testbench

//  Receive side of the FPGA1->FPGA2 link. Answers the sender's req with rdy,

---
 rtl/fpga2_receiver.sv | 226 ++++++++++++++++++++++
 tb/tb_fpga2_receiver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga2_receiver.sv
`default_nettype none
// ============================================================================
// Module  : fpga2_receiver
// Purpose : FPGA1->FPGA2 link receiver; captures a fixed burst, acks or
//           nacks it, then streams the buffered frame downstream.
// Rev     : 1.0
// ============================================================================
module fpga2_receiver #(
   parameter int WORDS         = 10,
   parameter int CAPTURE_DELAY = 3,
   parameter int TIMEOUT       = 64,
   parameter int NACK_CYCLES   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_in,
   input  logic [31:0] data_in,
   input  logic        send_done_in,
   output logic        rdy_out,
   output logic        ack_out,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        frame_done,
   output logic        frame_err
);

   localparam int PW = $clog2(WORDS + 1);
   localparam int DW = $clog2(CAPTURE_DELAY + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int NW = $clog2(NACK_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READY     = 3'd1,
      S_CAPTURE   = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_ACK       = 3'd4,
      S_NACK      = 3'd5,
      S_DRAIN     = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic            rdy_q, rdy_d;
   logic            ack_q, ack_d;
   logic            m_valid_q, m_valid_d;
   logic [31:0]     m_data_q, m_data_d;
   logic            frame_done_q, frame_done_d;
   logic            frame_err_q, frame_err_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0]   dly_q, dly_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [NW-1:0]   ncnt_q, ncnt_d;
   logic [PW-1:0]   rd_next;
   logic            buf_we;
   logic [31:0]     frame_buf_q [WORDS];

   assign rd_next = rd_ptr_q + PW'(1);

   always_comb begin
      state_d      = state_q;
      rdy_d        = rdy_q;
      ack_d        = ack_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      dly_d        = dly_q;
      tmo_d        = tmo_q;
      ncnt_d       = ncnt_q;
      buf_we       = 1'b0;

      case (state_q)
         S_IDLE: begin
            rdy_d = 1'b0;
            ack_d = 1'b0;
            if (req_in) begin
               rdy_d    = 1'b1;
               dly_d    = '0;
               wr_ptr_d = '0;
               state_d  = (CAPTURE_DELAY == 1) ? S_CAPTURE : S_READY;
            end
         end

         S_READY: begin
            if (!req_in) begin
               state_d     = S_IDLE;
               rdy_d       = 1'b0;
               frame_err_d = 1'b1;
            end else if (send_done_in) begin
               state_d     = S_NACK;
               rdy_d       = 1'b0;
               ncnt_d      = '0;
               frame_err_d = 1'b1;
            end else if (dly_q == DW'(CAPTURE_DELAY - 2)) begin
               state_d = S_CAPTURE;
            end else begin
               dly_d = dly_q + DW'(1);
            end
         end

         // A marker on the edge of the last word still counts as a short frame.
         S_CAPTURE: begin
            if (!req_in) begin
               state_d     = S_IDLE;
               rdy_d       = 1'b0;
               frame_err_d = 1'b1;
            end else if (send_done_in) begin
               state_d     = S_NACK;
               rdy_d       = 1'b0;
               ncnt_d      = '0;
               frame_err_d = 1'b1;
            end else begin
               buf_we = 1'b1;
               if (wr_ptr_q == PW'(WORDS - 1)) begin
                  state_d = S_WAIT_DONE;
                  tmo_d   = '0;
               end else begin
                  wr_ptr_d = wr_ptr_q + PW'(1);
               end
            end
         end

         S_WAIT_DONE: begin
            if (!req_in) begin
               state_d     = S_IDLE;
               rdy_d       = 1'b0;
               frame_err_d = 1'b1;
            end else if (send_done_in) begin
               state_d = S_ACK;
               ack_d   = 1'b1;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d     = S_NACK;
               rdy_d       = 1'b0;
               ncnt_d      = '0;
               frame_err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_ACK: begin
            if (!req_in) begin
               state_d   = S_DRAIN;
               ack_d     = 1'b0;
               rdy_d     = 1'b0;
               rd_ptr_d  = '0;
               m_valid_d = 1'b1;
               m_data_d  = frame_buf_q[0];
            end
         end

         // IDLE needs one edge to re-raise rdy, so NACK itself lasts one cycle less.
         S_NACK: begin
            if (ncnt_q == NW'(NACK_CYCLES - 2)) begin
               state_d = S_IDLE;
            end else begin
               ncnt_d = ncnt_q + NW'(1);
            end
         end

         S_DRAIN: begin
            if (m_ready) begin
               if (rd_ptr_q == PW'(WORDS - 1)) begin
                  m_valid_d    = 1'b0;
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  rd_ptr_d = rd_next;
                  m_data_d = frame_buf_q[rd_next];
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rdy_q        <= 1'b0;
         ack_q        <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         dly_q        <= '0;
         tmo_q        <= '0;
         ncnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         rdy_q        <= rdy_d;
         ack_q        <= ack_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         dly_q        <= dly_d;
         tmo_q        <= tmo_d;
         ncnt_q       <= ncnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         frame_buf_q[wr_ptr_q] <= data_in;
      end
   end

   assign rdy_out    = rdy_q;
   assign ack_out    = ack_q;
   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga2_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpga2_receiver
// Purpose : Directed self-checking bench for fpga2_receiver.
// Rev     : 1.0
// ============================================================================
module tb_fpga2_receiver;

   localparam int WORDS = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_in = 1'b0;
   logic [31:0] data_in = '0;
   logic        send_done_in = 1'b0;
   logic        m_ready = 1'b1;
   logic        rdy_out, ack_out, m_valid, frame_done, frame_err;
   logic [31:0] m_data;

   int n_tests = 0;
   int n_fail  = 0;
   int err_cnt = 0;
   int done_cnt = 0;
   int ack_cnt = 0;
   int mv_cnt = 0;

   always #5 clk = ~clk;

   fpga2_receiver #(
      .WORDS(WORDS), .CAPTURE_DELAY(3), .TIMEOUT(64), .NACK_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
      .send_done_in(send_done_in), .rdy_out(rdy_out), .ack_out(ack_out),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always @(negedge clk) begin
      if (frame_err === 1'b1) err_cnt++;
      if (frame_done === 1'b1) done_cnt++;
      if (ack_out === 1'b1) ack_cnt++;
      if (m_valid === 1'b1) mv_cnt++;
   end

   typedef struct {
      logic        rst;
      logic        req;
      logic [31:0] data;
      logic        done;
      logic [37:0] exp; // {rdy, ack, m_valid, m_data, frame_done, frame_err}
   } vec_t;

   vec_t vecs [12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      err_cnt = 0; done_cnt = 0; ack_cnt = 0; mv_cnt = 0;
   endtask

   // Called right after E0; word i lands at edge E0+3+i.
   task automatic capture_words(input logic [31:0] base, input int n);
      for (int e = 1; e <= 2; e++) begin
         data_in = 32'hDEAD_0000 + e;
         step();
      end
      for (int i = 0; i < n; i++) begin
         data_in = base + i;
         step();
      end
      data_in = 32'hBAD0_BAD0;
   endtask

   task automatic drain(input logic [31:0] base, input bit toggle, input int stop_at);
      int got;
      bit order_ok, stable_ok, hold, done_ok;
      logic [31:0] prev;
      got = 0; order_ok = 1; stable_ok = 1; hold = 0; done_ok = 0; prev = '0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (m_valid !== 1'b1) break;
         if (stop_at >= 0 && got == stop_at) break;
         if (hold && m_data !== prev) stable_ok = 0;
         m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (m_ready) begin
            if (m_data !== base + got) order_ok = 0;
            got++;
         end
         hold = !m_ready;
         prev = m_data;
         step();
         if (got == WORDS && frame_done === 1'b1) done_ok = 1;
      end
      m_ready = 1'b1;
      if (stop_at >= 0) begin
         check("drain partial count", 64'(got), 64'(stop_at));
         check("drain partial m_data", 64'(m_data), 64'(base + stop_at));
      end else begin
         check("drain word count", 64'(got), 64'(WORDS));
         check("drain word order", 64'(order_ok), 64'd1);
         if (toggle) check("m_data stable while stalled", 64'(stable_ok), 64'd1);
         check("frame_done after last accept", 64'(done_ok), 64'd1);
      end
   endtask

   // Called right after E0: captures, acks, releases req and drains.
   task automatic frame_body(input logic [31:0] base, input bit toggle, input int stop_at);
      capture_words(base, WORDS);
      send_done_in = 1'b1;
      step();
      check("ack rises on marker", 64'(ack_out), 64'd1);
      step();
      step();
      send_done_in = 1'b0;
      check("ack/rdy held", 64'({rdy_out, ack_out}), 64'b11);
      req_in = 1'b0;
      step();
      check("drain entry flags", 64'({rdy_out, ack_out, m_valid}), 64'b001);
      check("drain first word", 64'(m_data), 64'(base));
      drain(base, toggle, stop_at);
   endtask

   initial begin
      // Reset then abort after word 4: cycle by cycle.
      vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, {3'b000, 32'h0, 2'b00}};
      vecs[1]  = '{1'b0, 1'b1, 32'h0,   1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[2]  = '{1'b0, 1'b1, 32'h77,  1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[3]  = '{1'b0, 1'b1, 32'h78,  1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[4]  = '{1'b0, 1'b1, 32'h500, 1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[5]  = '{1'b0, 1'b1, 32'h501, 1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[6]  = '{1'b0, 1'b1, 32'h502, 1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[7]  = '{1'b0, 1'b1, 32'h503, 1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[8]  = '{1'b0, 1'b1, 32'h504, 1'b0, {3'b100, 32'h0, 2'b00}};
      vecs[9]  = '{1'b0, 1'b0, 32'h505, 1'b0, {3'b000, 32'h0, 2'b01}};
      vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, {3'b000, 32'h0, 2'b00}};
      vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, {3'b000, 32'h0, 2'b00}};

      step();
      clear_counts();
      for (int i = 0; i < 12; i++) begin
         rst = vecs[i].rst; req_in = vecs[i].req;
         data_in = vecs[i].data; send_done_in = vecs[i].done;
         step();
         check($sformatf("vector %0d outputs", i),
               64'({rdy_out, ack_out, m_valid, m_data, frame_done, frame_err}),
               64'(vecs[i].exp));
      end
      step();
      check("abort: no ack", 64'(ack_cnt), 64'd0);
      check("abort: no m_valid", 64'(mv_cnt), 64'd0);
      check("abort: one frame_err", 64'(err_cnt), 64'd1);

      // Clean frame, downstream always ready.
      clear_counts();
      req_in = 1'b1;
      step();
      check("E0 rdy rise", 64'(rdy_out), 64'd1);
      frame_body(32'h100, 1'b0, -1);
      step();
      check("frame1 frame_done count", 64'(done_cnt), 64'd1);
      check("frame1 frame_err count", 64'(err_cnt), 64'd0);
      check("frame1 ack cycles", 64'(ack_cnt), 64'd3);

      // Same frame with a stalling downstream.
      clear_counts();
      req_in = 1'b1;
      step();
      frame_body(32'h100, 1'b1, -1);
      step();
      check("frame2 frame_done count", 64'(done_cnt), 64'd1);

      // Short frame: marker after 6 words, then resend.
      clear_counts();
      req_in = 1'b1;
      step();
      capture_words(32'h200, 6);
      send_done_in = 1'b1;
      step();
      send_done_in = 1'b0;
      check("short: nack entry", 64'({rdy_out, ack_out, frame_err}), 64'b001);
      step();
      check("short: rdy low 2nd cycle", 64'({rdy_out, frame_err}), 64'b00);
      step();
      check("short: re-armed rdy", 64'(rdy_out), 64'd1);
      check("short: no ack during nack", 64'(ack_cnt), 64'd0);
      frame_body(32'h300, 1'b0, -1);
      step();
      check("resend frame_done count", 64'(done_cnt), 64'd1);
      check("resend frame_err count", 64'(err_cnt), 64'd1);

      // Missing marker: timeout.
      begin
         bit waiting_ok;
         clear_counts();
         waiting_ok = 1;
         req_in = 1'b1;
         step();
         capture_words(32'h400, WORDS);
         for (int k = 1; k < 64; k++) begin
            step();
            if (rdy_out !== 1'b1 || frame_err !== 1'b0) waiting_ok = 0;
         end
         check("timeout: still waiting at 63", 64'(waiting_ok), 64'd1);
         step();
         check("timeout: nack at 64", 64'({rdy_out, frame_err}), 64'b01);
         req_in = 1'b0;
         step();
         step();
         step();
         check("timeout: no m_valid", 64'(mv_cnt), 64'd0);
         check("timeout: no ack", 64'(ack_cnt), 64'd0);
      end

      // Reset during drain at word 3, then a clean frame.
      clear_counts();
      req_in = 1'b1;
      step();
      frame_body(32'h600, 1'b0, 3);
      rst = 1'b1;
      step();
      check("reset in drain: outputs",
            64'({rdy_out, ack_out, m_valid, m_data, frame_done, frame_err}), 64'd0);
      rst = 1'b0;
      clear_counts();
      req_in = 1'b1;
      step();
      check("post-reset rdy rise", 64'(rdy_out), 64'd1);
      frame_body(32'h700, 1'b0, -1);
      step();
      check("post-reset frame_done count", 64'(done_cnt), 64'd1);
      check("post-reset frame_err count", 64'(err_cnt), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
